// File: rtl/shear_sort_ctrl.sv
// -----------------------------------------------------------------------------
// shear_sort_ctrl
//   Central sequencer for shear sort on a SIDE x SIDE mesh of processing
//   elements. A start request produces a one-cycle load strobe. The block then
//   issues odd-even transposition compare-exchange steps, phase by phase:
//   row phase (snake order), column phase, row phase, ... ending on a row
//   phase. When the final step is accepted it pulses done and raises sorted.
//   All controls are broadcast to every PE.
//
// Ports
//   clk       clock
//   rst       synchronous reset, active-high; wins over every other input
//   start     begin a sort; only honoured while idle
//   ce_ready  AND of all PE ready flags; a step is accepted on ce_valid & ce_ready
//   load_en   one-cycle pulse: PEs latch their initial element
//   ce_valid  a compare-exchange step is presented this cycle
//   ce_row    1 = row phase (even rows ascending, odd rows descending),
//             0 = column phase
//   ce_odd    step parity: 0 = pairs (0,1)(2,3)..., 1 = pairs (1,2)(3,4)...
//   phase_o   current phase index, 0..2*LOG_SIDE
//   step_o    current step index within the phase, 0..SIDE-1
//   busy      high from the load cycle through the final accepted step
//   done      one-cycle pulse after the final step is accepted
//   sorted    level; set with done, cleared by start or rst
// -----------------------------------------------------------------------------
module shear_sort_ctrl #(
   parameter int N        = 16,
   parameter int SIDE     = 4,
   parameter int LOG_SIDE = 2,
   parameter int PHASE_W  = 3,
   parameter int STEP_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               ce_ready,
   output logic               load_en,
   output logic               ce_valid,
   output logic               ce_row,
   output logic               ce_odd,
   output logic [PHASE_W-1:0] phase_o,
   output logic [STEP_W-1:0]  step_o,
   output logic               busy,
   output logic               done,
   output logic               sorted
);

   // The mesh must be square; catch a bad parameter set at elaboration.
   if (SIDE * SIDE != N) begin : g_bad_size
      $error("shear_sort_ctrl: N must equal SIDE*SIDE");
   end

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(2 * LOG_SIDE);
   localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(SIDE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;

   // Every output is a register. ce_row / ce_odd are loaded with the parity
   // of the phase/step being moved to, so they always agree with phase_o and
   // step_o in the same cycle.
   // NOTE: all state here is updated with non-blocking assignments so every
   // register sees the pre-edge values of the others, as real flops do.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         load_en  <= 1'b0;
         ce_valid <= 1'b0;
         ce_row   <= 1'b0;
         ce_odd   <= 1'b0;
         phase_o  <= '0;
         step_o   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sorted   <= 1'b0;
      end else begin
         // Strobes default low; the state that owns them raises them.
         load_en <= 1'b0;
         done    <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state   <= LOAD;
                  load_en <= 1'b1;
                  busy    <= 1'b1;
                  sorted  <= 1'b0;
               end
            end

            LOAD: begin
               state    <= RUN;
               ce_valid <= 1'b1;
               ce_row   <= 1'b1;   // phase 0 is a row phase
               ce_odd   <= 1'b0;   // step 0 is even
               phase_o  <= '0;
               step_o   <= '0;
            end

            RUN: begin
               // A stalled step (ce_ready low) leaves every output untouched.
               if (ce_ready) begin
                  if (step_o != LAST_STEP) begin
                     step_o <= step_o + 1'b1;
                     ce_odd <= ~step_o[0];
                  end else if (phase_o != LAST_PHASE) begin
                     step_o  <= '0;
                     ce_odd  <= 1'b0;
                     phase_o <= phase_o + 1'b1;
                     // Next phase is even (row) exactly when this one is odd.
                     ce_row  <= phase_o[0];
                  end else begin
                     // Final step of the final row phase: phase stays put.
                     state    <= DONE;
                     ce_valid <= 1'b0;
                     ce_row   <= 1'b0;
                     ce_odd   <= 1'b0;
                     step_o   <= '0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     sorted   <= 1'b1;
                  end
               end
            end

            DONE: begin
               state   <= IDLE;
               phase_o <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shear_sort_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shear_sort_ctrl
//   Self-checking bench for shear_sort_ctrl. Two instances are built: the
//   default 4x4 mesh and an 8x8 mesh. The expected step sequence is derived
//   from the sort schedule itself: (2*log2(side)+1) phases of side steps,
//   even phases are row phases, step parity alternates within each phase.
// -----------------------------------------------------------------------------
module tb_shear_sort_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic ce_ready;
   logic sel;          // 0 = 4x4 instance, 1 = 8x8 instance

   logic       l4, v4, r4, o4, b4, d4, s4;
   logic [2:0] p4;
   logic [1:0] t4;
   logic       l8, v8, r8, o8, b8, d8, s8;
   logic [2:0] p8;
   logic [2:0] t8;

   int total = 0;
   int bad   = 0;
   int acc_cnt = 0;

   always #5 clk = ~clk;

   shear_sort_ctrl #(.N(16), .SIDE(4), .LOG_SIDE(2), .PHASE_W(3), .STEP_W(2)) dut4 (
      .clk      (clk),
      .rst      (rst),
      .start    (start & ~sel),
      .ce_ready (ce_ready),
      .load_en  (l4),
      .ce_valid (v4),
      .ce_row   (r4),
      .ce_odd   (o4),
      .phase_o  (p4),
      .step_o   (t4),
      .busy     (b4),
      .done     (d4),
      .sorted   (s4)
   );

   shear_sort_ctrl #(.N(64), .SIDE(8), .LOG_SIDE(3), .PHASE_W(3), .STEP_W(3)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .start    (start & sel),
      .ce_ready (ce_ready),
      .load_en  (l8),
      .ce_valid (v8),
      .ce_row   (r8),
      .ce_odd   (o8),
      .phase_o  (p8),
      .step_o   (t8),
      .busy     (b8),
      .done     (d8),
      .sorted   (s8)
   );

   // Observed bundle of the selected instance:
   // {load_en, ce_valid, ce_row, ce_odd, busy, done, sorted, phase[2:0], step[2:0]}
   logic [12:0] obs;
   assign obs = sel ? {l8, v8, r8, o8, b8, d8, s8, p8, t8}
                    : {l4, v4, r4, o4, b4, d4, s4, p4, 1'b0, t4};

   // Scoreboard of accepted steps on the selected instance.
   always @(posedge clk) begin
      if (obs[11] && ce_ready) acc_cnt <= acc_cnt + 1;
   end

   function automatic logic [12:0] pk(input bit l, input bit v, input bit r,
                                      input bit o, input bit b, input bit d,
                                      input bit s, input int ph, input int st);
      return {l, v, r, o, b, d, s, 3'(ph), 3'(st)};
   endfunction

   // One full sort on the selected instance.
   //   stall_idx/stall_n : hold ce_ready low stall_n cycles on step stall_idx
   //   rnd               : random stall length (0..2) on every step instead
   //   restart_idx       : raise start during that step (must be ignored)
   //   abort_idx         : assert rst during that step and stop there
   task automatic run_sort(input string name, input bit s8_sel, input int side,
                           input int lg, input int stall_idx, input int stall_n,
                           input bit rnd, input int restart_idx, input int abort_idx);
      int nsteps;
      int stalls;
      int lat;
      int sn;
      int ph;
      int st;
      logic [12:0] exp_v;
      nsteps = (2 * lg + 1) * side;
      stalls = 0;
      @(negedge clk);
      sel      = s8_sel;
      start    = 1'b1;
      ce_ready = 1'b1;
      acc_cnt  = 0;
      @(posedge clk);            // start-sampling edge t
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      exp_v = pk(1, 0, 0, 0, 1, 0, 0, 0, 0);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s load: got %h expected %h", name, obs, exp_v);
      end
      @(posedge clk);
      lat++;
      for (int k = 0; k < nsteps; k++) begin
         ph = k / side;
         st = k % side;
         if (rnd) sn = int'($urandom_range(0, 2));
         else     sn = (k == stall_idx) ? stall_n : 0;
         stalls += sn;
         for (int s = 0; s <= sn; s++) begin
            @(negedge clk);
            exp_v = pk(0, 1, (ph % 2) == 0, (st % 2) == 1, 1, 0, 0, ph, st);
            total++;
            if (obs !== exp_v) begin
               bad++;
               $display("FAIL %s step%0d.%0d: got %h expected %h", name, k, s, obs, exp_v);
            end
            if (k == abort_idx) begin
               rst = 1'b1;
               @(posedge clk);
               @(negedge clk);
               rst = 1'b0;
               exp_v = '0;
               total++;
               if (obs !== exp_v) begin
                  bad++;
                  $display("FAIL %s abort: got %h expected %h", name, obs, exp_v);
               end
               return;
            end
            start    = (k == restart_idx);
            ce_ready = (s < sn) ? 1'b0 : 1'b1;
            @(posedge clk);
            lat++;
         end
      end
      @(negedge clk);
      start = 1'b0;
      exp_v = pk(0, 0, 0, 0, 0, 1, 1, 2 * lg, 0);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s done: got %h expected %h", name, obs, exp_v);
      end
      total++;
      if (lat != 2 * nsteps / nsteps + nsteps + stalls) begin
         bad++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, nsteps + 2 + stalls);
      end
      total++;
      if (acc_cnt != nsteps) begin
         bad++;
         $display("FAIL %s accepted: got %0d expected %0d", name, acc_cnt, nsteps);
      end
      @(negedge clk);
      exp_v = pk(0, 0, 0, 0, 0, 0, 1, 0, 0);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s idle_after: got %h expected %h", name, obs, exp_v);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      ce_ready = 1'b1;
      sel = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if (obs !== 13'd0) begin
         bad++;
         $display("FAIL reset4: got %h expected %h", obs, 13'd0);
      end
      sel = 1'b1;
      #1;
      total++;
      if (obs !== 13'd0) begin
         bad++;
         $display("FAIL reset8: got %h expected %h", obs, 13'd0);
      end
      sel = 1'b0;
   endtask

   task automatic test_basic();
      run_sort("basic", 1'b0, 4, 2, -1, 0, 1'b0, -1, -1);
   endtask

   task automatic test_stall();
      // phase 1, step 2 -> step index 6
      run_sort("stall", 1'b0, 4, 2, 6, 3, 1'b0, -1, -1);
   endtask

   task automatic test_start_ignored();
      // start raised in the cycle that is t+10
      run_sort("restart", 1'b0, 4, 2, -1, 0, 1'b0, 8, -1);
   endtask

   task automatic test_rst_mid_run();
      // phase 2, step 1 -> step index 9
      run_sort("abort", 1'b0, 4, 2, -1, 0, 1'b0, -1, 9);
      run_sort("after_abort", 1'b0, 4, 2, -1, 0, 1'b0, -1, -1);
   endtask

   task automatic test_rst_with_start();
      @(negedge clk);
      sel = 1'b0;
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      total++;
      if (obs !== 13'd0) begin
         bad++;
         $display("FAIL rst_start: got %h expected %h", obs, 13'd0);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (obs !== 13'd0) begin
         bad++;
         $display("FAIL rst_start_idle: got %h expected %h", obs, 13'd0);
      end
   endtask

   task automatic test_random_ready();
      for (int i = 0; i < 3; i++) begin
         run_sort("random", 1'b0, 4, 2, -1, 0, 1'b1, -1, -1);
      end
   endtask

   task automatic test_side8();
      run_sort("side8", 1'b1, 8, 3, -1, 0, 1'b0, -1, -1);
      run_sort("side8_rnd", 1'b1, 8, 3, -1, 0, 1'b1, -1, -1);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      ce_ready = 1'b1;
      sel = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_start_ignored();
      test_rst_mid_run();
      test_rst_with_start();
      test_random_ready();
      test_side8();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
